// File: rtl/pipeline_2_execute_reg_if.sv
// Read-reg to execute pipeline register bundle: stage inputs, writeback bypass and EX-stage outputs.
interface pipeline_2_execute_reg_if;
    logic        update;
    logic        flush;
    logic        in_valid;
    logic [21:0] control_in;
    logic [2:0]  num_Rm_in;
    logic [2:0]  num_Rn_in;
    logic [2:0]  num_Rd_in;
    logic [2:0]  used_RmRnRd_in;
    logic [15:0] imm_in;
    logic [5:0]  inst_type_in;
    logic [15:0] delayed_B_in;
    logic [2:0]  delayed_cond_in;
    logic [15:0] value_A_in;
    logic [15:0] value_B_in;
    logic        wb_en;
    logic [2:0]  wb_num;
    logic [15:0] wb_data;
    logic        valid_out;
    logic [21:0] control_out;
    logic [2:0]  num_Rd_out;
    logic [15:0] imm_out;
    logic [5:0]  inst_type_out;
    logic [15:0] delayed_B_out;
    logic [2:0]  delayed_cond_out;
    logic [15:0] A_out;
    logic [15:0] B_out;
    logic        loads_out;
    logic        stall_out;
    logic [15:0] hazard_count;

    modport slave (
        input  update, flush, in_valid, control_in, num_Rm_in, num_Rn_in, num_Rd_in,
               used_RmRnRd_in, imm_in, inst_type_in, delayed_B_in, delayed_cond_in,
               value_A_in, value_B_in, wb_en, wb_num, wb_data,
        output valid_out, control_out, num_Rd_out, imm_out, inst_type_out, delayed_B_out,
               delayed_cond_out, A_out, B_out, loads_out, stall_out, hazard_count
    );

    modport master (
        output update, flush, in_valid, control_in, num_Rm_in, num_Rn_in, num_Rd_in,
               used_RmRnRd_in, imm_in, inst_type_in, delayed_B_in, delayed_cond_in,
               value_A_in, value_B_in, wb_en, wb_num, wb_data,
        input  valid_out, control_out, num_Rd_out, imm_out, inst_type_out, delayed_B_out,
               delayed_cond_out, A_out, B_out, loads_out, stall_out, hazard_count
    );
endinterface

// File: rtl/pipeline_2_execute_reg.sv
// Execute-stage pipeline register with writeback bypass and load-use interlock.
// Latency 1 cycle; update=0 or a load-use hazard holds upstream via combinational stall_out.
module pipeline_2_execute_reg (
    input logic                     clk,
    input logic                     rst,
    pipeline_2_execute_reg_if.slave bus
);
    logic        r_valid;
    logic [21:0] r_control;
    logic [2:0]  r_num_rd;
    logic [15:0] r_imm;
    logic [5:0]  r_inst_type;
    logic [15:0] r_delayed_b;
    logic [2:0]  r_delayed_cond;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_hazard_count;

    logic        w_match;
    logic        w_loads;
    logic        w_hazard;
    logic [15:0] w_fwd_a;
    logic [15:0] w_fwd_b;

    assign w_match = (bus.used_RmRnRd_in[2] & (bus.num_Rm_in == r_num_rd))
                   | (bus.used_RmRnRd_in[1] & (bus.num_Rn_in == r_num_rd))
                   | (bus.used_RmRnRd_in[0] & (bus.num_Rd_in == r_num_rd));
    assign w_loads  = r_valid & r_control[8];
    assign w_hazard = r_valid & w_loads & bus.in_valid & w_match & ~bus.flush;

    // Writeback data is bypassed only on the capture edge; held operands keep their old value.
    assign w_fwd_a = (bus.wb_en && bus.wb_num == bus.num_Rm_in) ? bus.wb_data : bus.value_A_in;
    assign w_fwd_b = (bus.wb_en && bus.wb_num == bus.num_Rn_in) ? bus.wb_data : bus.value_B_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid        <= 1'b0;
            r_control      <= '0;
            r_num_rd       <= '0;
            r_imm          <= '0;
            r_inst_type    <= '0;
            r_delayed_b    <= '0;
            r_delayed_cond <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_hazard_count <= '0;
        end else if (bus.update) begin
            if (bus.flush) begin
                r_valid   <= 1'b0;
                r_control <= '0;
            end else if (w_hazard) begin
                // Bubble; the incoming instruction stays upstream and is taken next cycle.
                r_valid   <= 1'b0;
                r_control <= '0;
                if (r_hazard_count != 16'hFFFF)
                    r_hazard_count <= r_hazard_count + 16'd1;
            end else begin
                r_valid        <= bus.in_valid;
                r_control      <= bus.in_valid ? bus.control_in : 22'd0;
                r_num_rd       <= bus.num_Rd_in;
                r_imm          <= bus.imm_in;
                r_inst_type    <= bus.inst_type_in;
                r_delayed_b    <= bus.delayed_B_in;
                r_delayed_cond <= bus.delayed_cond_in;
                r_a            <= w_fwd_a;
                r_b            <= w_fwd_b;
            end
        end
    end

    assign bus.valid_out        = r_valid;
    assign bus.control_out      = r_control;
    assign bus.num_Rd_out       = r_num_rd;
    assign bus.imm_out          = r_imm;
    assign bus.inst_type_out    = r_inst_type;
    assign bus.delayed_B_out    = r_delayed_b;
    assign bus.delayed_cond_out = r_delayed_cond;
    assign bus.A_out            = r_a;
    assign bus.B_out            = r_b;
    assign bus.loads_out        = w_loads;
    assign bus.stall_out        = ~bus.update | w_hazard;
    assign bus.hazard_count     = r_hazard_count;
endmodule

// File: doc/pipeline_2_execute_reg.md
PIPELINE_2_EXECUTE_REG -- requirements
Module: pipeline_2_execute_reg

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-low reset, with ports named as below.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset.
- update  in  1  global advance enable; 0 = whole pipeline held.
- flush  in  1  kill the instruction entering the execute stage (taken branch / redirect).
- in_valid  in  1  read-reg stage holds a real instruction.
- control_in  in  22  control word from read-reg stage; bit 8 = load.
- num_Rm_in, num_Rn_in, num_Rd_in  in  3 each  register numbers.
- used_RmRnRd_in  in  3  operand-use flags: [2]=Rm, [1]=Rn, [0]=Rd used as source.
- imm_in  in  16  immediate.
- inst_type_in  in  6  instruction class.
- delayed_B_in  in  16  delayed-branch target.
- delayed_cond_in  in  3  delayed-branch condition.
- value_A_in, value_B_in  in  16 each  register-file reads of Rm and Rn.
- wb_en  in  1  writeback stage writes a register this cycle.
- wb_num  in  3  writeback register number.
- wb_data  in  16  writeback data.
- valid_out  out  1  execute stage holds a real instruction.
- control_out  out  22  latched control word.
- num_Rd_out  out  3  latched destination number.
- imm_out  out  16  latched immediate.
- inst_type_out  out  6  latched instruction class.
- delayed_B_out  out  16  latched branch target.
- delayed_cond_out  out  3  latched branch condition.
- A_out, B_out  out  16 each  latched, forwarded operands.
- loads_out  out  1  control_out[8] AND valid_out.
- stall_out  out  1  upstream stages hold (combinational).
- hazard_count  out  16  saturating load-use stall counter.

Function
REQ-002 match SHALL be (used[2] & Rm_in==num_Rd_out) | (used[1] & Rn_in==num_Rd_out) | (used[0] & Rd_in==num_Rd_out).
REQ-003 hazard SHALL be valid_out & loads_out & in_valid & match & ~flush.
REQ-004 stall_out SHALL be ~update | hazard, combinationally.
REQ-005 The block SHALL hold every register unchanged when update=0, regardless of flush or hazard.
REQ-006 With update=1 and flush=1, the block SHALL load a bubble: valid_out=0 and control_out=0; the other fields are don't-care. Flush has priority over hazard.
REQ-007 With update=1 and hazard=1, the block SHALL load a bubble and SHALL NOT consume the incoming instruction.
REQ-008 After the bubble, hazard deasserts because valid_out=0, so exactly one bubble cycle SHALL be inserted per load-use pair.
REQ-009 With update=1 and no flush or hazard, the block SHALL capture all *_in fields; valid_out SHALL take in_valid, and control_out SHALL take in_valid ? control_in : 0.
REQ-010 The captured A SHALL be (wb_en & wb_num==num_Rm_in) ? wb_data : value_A_in; B SHALL follow the same rule with num_Rn_in.
REQ-011 Forwarding SHALL apply on the capture edge only; held values are not re-forwarded while update=0.
REQ-012 hazard_count SHALL increment by 1 on each edge with update=1 and hazard=1, and SHALL saturate at 0xFFFF with no wrap.
REQ-013 loads_out SHALL never be 1 while valid_out=0.

Reset
REQ-014 On a rising edge with rst=0, all registered outputs SHALL clear to 0: valid_out, control_out, num_Rd_out, imm_out, inst_type_out, delayed_B_out, delayed_cond_out, A_out, B_out, hazard_count.
REQ-015 Reset SHALL take priority over update, flush and hazard.
REQ-016 Reset asserted mid-stall SHALL clear hazard and stall_out in the next cycle, provided update=1.

Verification
REQ-017 The bench SHALL cover these scenarios:
- Load-use: EX holds a load to R3 with valid=1; incoming instruction has used=100, Rm=3 -> stall_out=1 for 1 cycle, a bubble (valid_out=0), then the instruction is captured, hazard_count=1.
- No false hazard: EX holds a load to R3; incoming instruction has used=000, Rm=3 -> stall_out=0, captured immediately.
- Forwarding: wb_en=1, wb_num=2, wb_data=0x1234; incoming Rm=2, value_A_in=0xAAAA -> A_out=0x1234.
- Flush vs hazard: hazard conditions plus flush=1 -> bubble, stall_out=0, hazard_count unchanged.
- Hold: update=0 for 3 cycles with changing inputs -> all outputs stable, stall_out=1.
- Saturation and reset: hazard_count preset to 0xFFFF, another hazard -> stays 0xFFFF; then rst=0 for one edge -> all outputs 0.
